bip_debug_unit: RTL and testbench

UART-driven debug controller for the BIP-I CPU. Loads program memory from host bytes, then sequences the CPU in RUN-to-halt or single-STEP mode by gating its clock enable. After each run or step it reports PC, ACC and the executed-cycle count back over the UART transmitter. It sits in `cpu_top` between the UART rx/tx cores and the CPU datapath/instruction memory.

---
 rtl/bip_debug_unit_if.sv | 31 +++
 rtl/bip_debug_unit.sv | 202 ++++++++++++++++++++
 tb/tb_bip_debug_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/bip_debug_unit_if.sv
// Bus bundle between the BIP-I debug unit and its UART cores, instruction memory and CPU.
// master: the debug unit; slave: the surrounding UART/CPU/memory side.
interface bip_debug_unit_if #(
    parameter int unsigned ADDR_W = 11
);
    logic              i_rx_done;
    logic [7:0]        i_rx_data;
    logic              i_tx_done;
    logic              o_tx_start;
    logic [7:0]        o_tx_data;
    logic              o_imem_we;
    logic [ADDR_W-1:0] o_imem_addr;
    logic [15:0]       o_imem_data;
    logic              o_cpu_en;
    logic              o_cpu_rst;
    logic              i_halt;
    logic [ADDR_W-1:0] i_pc;
    logic [15:0]       i_acc;

    modport master (
        input  i_rx_done, i_rx_data, i_tx_done, i_halt, i_pc, i_acc,
        output o_tx_start, o_tx_data, o_imem_we, o_imem_addr, o_imem_data,
               o_cpu_en, o_cpu_rst
    );

    modport slave (
        output i_rx_done, i_rx_data, i_tx_done, i_halt, i_pc, i_acc,
        input  o_tx_start, o_tx_data, o_imem_we, o_imem_addr, o_imem_data,
               o_cpu_en, o_cpu_rst
    );
endinterface

// File: rtl/bip_debug_unit.sv
// UART-driven debug controller for BIP-I: loads program memory, runs/steps the CPU
// through its clock enable and reports PC, ACC and executed-cycle count as 6 bytes.
module bip_debug_unit #(
    parameter int unsigned ADDR_W   = 11,
    parameter logic [7:0]  CMD_LOAD = 8'h01,
    parameter logic [7:0]  CMD_RUN  = 8'h02,
    parameter logic [7:0]  CMD_STEP = 8'h03
) (
    input  logic            i_clk,
    input  logic            i_rst,
    bip_debug_unit_if.master bus
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CYC_W  = 16;
    localparam int unsigned SNAP_W = 48;
    localparam int unsigned BIDX_W = 3;
    localparam int unsigned NBYTES = 6;

    typedef enum logic [3:0] {
        IDLE, LD_CNT_H, LD_CNT_L, LD_HI, LD_LO, LD_WR,
        CPU_RST, RUN, STEP, SEND, SEND_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_hi_q, cnt_hi_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [7:0]          word_hi_q, word_hi_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic [SNAP_W-1:0]   snap_q, snap_d;
    logic [BIDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [DATA_W-1:0]   imem_data_q, imem_data_d;
    logic                cpu_rst_q, cpu_rst_d;

    logic                cpu_en_c;
    logic [ADDR_W-1:0]   count_c;
    logic [SNAP_W-1:0]   live_c;
    logic [SNAP_W-1:0]   snap_src_c;
    logic [7:0]          byte_c;

    // Enable drops in the same cycle halt is seen, so the HALT instruction never executes.
    assign cpu_en_c = ((state_q == RUN) || (state_q == STEP)) && !bus.i_halt;
    assign count_c  = ADDR_W'({cnt_hi_q, bus.i_rx_data});
    assign live_c   = {DATA_W'(bus.i_pc), bus.i_acc, cyc_q};

    // Byte 0 is sent from live values so a just-completed step is reflected in the report.
    always_comb begin
        snap_src_c = (byte_idx_q == BIDX_W'(0)) ? live_c : snap_q;
        case (byte_idx_q)
            3'd0:    byte_c = snap_src_c[47:40];
            3'd1:    byte_c = snap_src_c[39:32];
            3'd2:    byte_c = snap_src_c[31:24];
            3'd3:    byte_c = snap_src_c[23:16];
            3'd4:    byte_c = snap_src_c[15:8];
            default: byte_c = snap_src_c[7:0];
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_hi_d    = cnt_hi_q;
        last_d      = last_q;
        idx_d       = idx_q;
        word_hi_d   = word_hi_q;
        cyc_d       = cpu_en_c ? cyc_q + CYC_W'(1) : cyc_q;
        snap_d      = snap_q;
        byte_idx_d  = byte_idx_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        imem_we_d   = 1'b0;
        imem_addr_d = imem_addr_q;
        imem_data_d = imem_data_q;
        cpu_rst_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_rx_done) begin
                    if (bus.i_rx_data == CMD_LOAD)      state_d = LD_CNT_H;
                    else if (bus.i_rx_data == CMD_RUN)  state_d = RUN;
                    else if (bus.i_rx_data == CMD_STEP) state_d = STEP;
                end
            end
            LD_CNT_H: begin
                if (bus.i_rx_done) begin
                    cnt_hi_d = bus.i_rx_data[2:0];
                    state_d  = LD_CNT_L;
                end
            end
            LD_CNT_L: begin
                if (bus.i_rx_done) begin
                    if (count_c == '0) begin
                        cpu_rst_d = 1'b1;
                        state_d   = CPU_RST;
                    end else begin
                        last_d  = count_c - ADDR_W'(1);
                        idx_d   = '0;
                        state_d = LD_HI;
                    end
                end
            end
            LD_HI: begin
                if (bus.i_rx_done) begin
                    word_hi_d = bus.i_rx_data;
                    state_d   = LD_LO;
                end
            end
            LD_LO: begin
                if (bus.i_rx_done) begin
                    imem_we_d   = 1'b1;
                    imem_addr_d = idx_q;
                    imem_data_d = {word_hi_q, bus.i_rx_data};
                    state_d     = LD_WR;
                end
            end
            LD_WR: begin
                if (idx_q == last_q) begin
                    cpu_rst_d = 1'b1;
                    state_d   = CPU_RST;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = LD_HI;
                end
            end
            CPU_RST: begin
                cyc_d   = '0;
                state_d = IDLE;
            end
            RUN: begin
                if (bus.i_halt) state_d = SEND;
            end
            STEP: begin
                state_d = SEND;
            end
            SEND: begin
                if (byte_idx_q == BIDX_W'(0)) snap_d = live_c;
                tx_start_d = 1'b1;
                tx_data_d  = byte_c;
                state_d    = SEND_WAIT;
            end
            SEND_WAIT: begin
                if (bus.i_tx_done) begin
                    if (byte_idx_q == BIDX_W'(NBYTES - 1)) begin
                        byte_idx_d = '0;
                        state_d    = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + BIDX_W'(1);
                        state_d    = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_hi_q    <= '0;
            last_q      <= '0;
            idx_q       <= '0;
            word_hi_q   <= '0;
            cyc_q       <= '0;
            snap_q      <= '0;
            byte_idx_q  <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            imem_we_q   <= 1'b0;
            imem_addr_q <= '0;
            imem_data_q <= '0;
            cpu_rst_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_hi_q    <= cnt_hi_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            word_hi_q   <= word_hi_d;
            cyc_q       <= cyc_d;
            snap_q      <= snap_d;
            byte_idx_q  <= byte_idx_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            imem_we_q   <= imem_we_d;
            imem_addr_q <= imem_addr_d;
            imem_data_q <= imem_data_d;
            cpu_rst_q   <= cpu_rst_d;
        end
    end

    assign bus.o_tx_start  = tx_start_q;
    assign bus.o_tx_data   = tx_data_q;
    assign bus.o_imem_we   = imem_we_q;
    assign bus.o_imem_addr = imem_addr_q;
    assign bus.o_imem_data = imem_data_q;
    assign bus.o_cpu_en    = cpu_en_c;
    assign bus.o_cpu_rst   = cpu_rst_q;
endmodule

// File: tb/tb_bip_debug_unit.sv
// Directed bench for bip_debug_unit: a toy CPU (PC+1, ACC+0x1234 per enabled cycle,
// halt at PC 3) and an auto-responding UART tx model feed hand-computed expectations.
module tb_bip_debug_unit;
    localparam int unsigned ADDR_W = 11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bip_debug_unit_if #(.ADDR_W(ADDR_W)) bus ();
    bip_debug_unit #(.ADDR_W(ADDR_W)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    logic [ADDR_W-1:0] pc  = '0;
    logic [15:0]       acc = '0;
    logic [7:0]        tx_hold;
    logic [7:0]        got[$];
    logic [15:0]       prog[3] = '{16'h1801, 16'h2002, 16'h0000};
    int tests = 0, fails = 0;
    int en_cnt = 0, wr_cnt = 0, rst_cnt = 0, start_cnt = 0, unstable = 0;
    int e0, w0, r0, s0;

    assign bus.i_pc   = pc;
    assign bus.i_acc  = acc;
    assign bus.i_halt = (pc == ADDR_W'(3));

    // CPU stand-in
    always @(posedge clk) begin
        if (bus.o_cpu_rst) begin
            pc  <= '0;
            acc <= '0;
        end else if (bus.o_cpu_en) begin
            pc  <= pc + ADDR_W'(1);
            acc <= acc + 16'h1234;
        end
    end

    always @(negedge clk) begin
        if (bus.o_cpu_en)   en_cnt++;
        if (bus.o_imem_we)  wr_cnt++;
        if (bus.o_cpu_rst)  rst_cnt++;
        if (bus.o_tx_start) start_cnt++;
    end

    // UART tx stand-in: captures each byte, answers with tx_done three cycles later
    initial begin
        bus.i_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_tx_start === 1'b1) begin
                got.push_back(bus.o_tx_data);
                tx_hold = bus.o_tx_data;
                repeat (2) begin
                    @(negedge clk);
                    if (bus.o_tx_data !== tx_hold) unstable++;
                end
                bus.i_tx_done = 1'b1;
                @(negedge clk);
                bus.i_tx_done = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d expected 0 remaining", 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        @(negedge clk);
        bus.i_rx_done = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " ctl"}, 32'({bus.o_tx_start, bus.o_tx_data, bus.o_imem_we,
                                  bus.o_cpu_en, bus.o_cpu_rst}), 32'h0);
        check({tag, " mem"}, 32'({bus.o_imem_addr, bus.o_imem_data}), 32'h0);
    endtask

    task automatic wait_report(input string tag, input logic [15:0] exp_pc,
                               input logic [15:0] exp_acc, input logic [15:0] exp_cyc);
        for (int i = 0; i < 400 && got.size() < 6; i++) @(negedge clk);
        repeat (6) @(negedge clk);
        check({tag, " bytes"}, 32'(got.size()), 32'd6);
        if (got.size() >= 6) begin
            check({tag, " pc"},  32'({got[0], got[1]}), 32'(exp_pc));
            check({tag, " acc"}, 32'({got[2], got[3]}), 32'(exp_acc));
            check({tag, " cyc"}, 32'({got[4], got[5]}), 32'(exp_cyc));
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.i_rx_done = 1'b0;
        bus.i_rx_data = 8'h00;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        // Load three words
        w0 = wr_cnt; r0 = rst_cnt;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h03);
        for (int i = 0; i < 3; i++) begin
            send_byte(prog[i][15:8]);
            send_byte(prog[i][7:0]);
            check($sformatf("load wr%0d", i),
                  32'({bus.o_imem_we, bus.o_imem_addr, bus.o_imem_data}),
                  32'({1'b1, ADDR_W'(i), prog[i]}));
        end
        @(negedge clk);
        check("load cpu_rst", 32'({bus.o_cpu_rst, bus.o_imem_we}), 32'h2);
        repeat (3) @(negedge clk);
        check("load wr count", 32'(wr_cnt - w0), 32'd3);
        check("load rst count", 32'(rst_cnt - r0), 32'd1);

        // Run to halt at PC 3
        got.delete(); e0 = en_cnt; s0 = start_cnt;
        send_byte(8'h02);
        check("run entry en", 32'(bus.o_cpu_en), 32'd1);
        wait_report("run", 16'h0003, 16'h369C, 16'h0003);
        check("run en cycles", 32'(en_cnt - e0), 32'd3);
        check("run starts", 32'(start_cnt - s0), 32'd6);

        // Run with halt already high
        got.delete(); e0 = en_cnt;
        send_byte(8'h02);
        check("halt entry en", 32'(bus.o_cpu_en), 32'd0);
        wait_report("halt entry", 16'h0003, 16'h369C, 16'h0003);
        check("halt en cycles", 32'(en_cnt - e0), 32'd0);

        // Unknown command byte
        e0 = en_cnt; s0 = start_cnt; w0 = wr_cnt; r0 = rst_cnt;
        send_byte(8'h7F);
        repeat (5) @(negedge clk);
        check("unknown quiet", 32'((en_cnt - e0) + (start_cnt - s0) + (wr_cnt - w0) + (rst_cnt - r0)), 32'd0);

        // Reload one word, then two single steps
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h18); send_byte(8'h01);
        check("reload wr", 32'({bus.o_imem_we, bus.o_imem_addr, bus.o_imem_data}), 32'({1'b1, ADDR_W'(0), 16'h1801}));
        repeat (3) @(negedge clk);
        got.delete(); e0 = en_cnt;
        send_byte(8'h03);
        check("step1 en", 32'(bus.o_cpu_en), 32'd1);
        wait_report("step1", 16'h0001, 16'h1234, 16'h0001);
        check("step1 en cycles", 32'(en_cnt - e0), 32'd1);
        got.delete(); e0 = en_cnt;
        send_byte(8'h03);
        wait_report("step2", 16'h0002, 16'h2468, 16'h0002);
        check("step2 en cycles", 32'(en_cnt - e0), 32'd1);

        // Zero-length load
        w0 = wr_cnt;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        check("zero load cpu_rst", 32'(bus.o_cpu_rst), 32'd1);
        repeat (3) @(negedge clk);
        check("zero load writes", 32'(wr_cnt - w0), 32'd0);

        // Host bytes arriving during a report are dropped
        got.delete(); e0 = en_cnt;
        send_byte(8'h03);
        send_byte(8'h02); send_byte(8'h01); send_byte(8'h03);
        wait_report("rx in send", 16'h0001, 16'h1234, 16'h0001);
        check("rx in send en", 32'(en_cnt - e0), 32'd1);
        check("tx data stable", 32'(unstable), 32'd0);

        // Reset after the high byte of word 1
        w0 = wr_cnt; r0 = rst_cnt;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h11); send_byte(8'h22);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("rst mid load");
        rst = 1'b0;
        send_byte(8'h33);
        repeat (5) @(negedge clk);
        check("mid load writes", 32'(wr_cnt - w0), 32'd1);
        check("mid load no cpu_rst", 32'(rst_cnt - r0), 32'd0);

        // Reset while reporting, after two bytes
        got.delete(); s0 = start_cnt;
        send_byte(8'h03);
        for (int i = 0; i < 200 && (start_cnt - s0) < 2; i++) @(negedge clk);
        check("send reached byte2", 32'(start_cnt - s0), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("rst mid send");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("no tx after rst", 32'(start_cnt - s0), 32'd2);
        check("partial byte count", 32'(got.size()), 32'd2);
        if (got.size() >= 2) check("partial pc bytes", 32'({got[0], got[1]}), 32'h0002);

        // Normal run after reset
        got.delete(); e0 = en_cnt;
        send_byte(8'h02);
        wait_report("run after rst", 16'h0003, 16'h369C, 16'h0001);
        check("run after rst en", 32'(en_cnt - e0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
